lfsr_gen: RTL
=============

# lfsr_gen

Parametrised Fibonacci LFSR pseudo-random source, the next generation of the team's fixed 8-bit generator. Width and tap mask are parameters. It adds clock enable, a run-time seed load, and all-zero seed protection. It also measures the sequence period in hardware, so a bench or a BIST controller can confirm maximal length. It sits beside the arbiter and stimulus logic as a shared random-number source.

## Interface
- WIDTH, 8, register width in bits (legal range 3..32)
- TAPS, lfsr_pkg::TAPS_8 (8'hB8), feedback mask; bit i set means state bit i feeds the XOR; bit WIDTH-1 must be set
- RESET_SEED, 1, state loaded while rst_n is low; a value of 0 is replaced by 1

- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- en  in  1  advance the LFSR one step this cycle
- load  in  1  load seed this cycle; has priority over en
- seed  in  WIDTH  value loaded when load=1; 0 is replaced by 1
- lfsr_out  out  WIDTH  current state, registered
- adv_cnt  out  WIDTH  advances since last reset, load or period completion
- period_done  out  1  one-cycle pulse: the state has returned to the start value
- period_len  out  WIDTH  length of the last completed period; holds until the next completion

## Operation
- Next state: next = {state[WIDTH-2:0], ^(state & TAPS)}, a left shift with the feedback entering at bit 0.
- Start register: holds the most recent loaded or reset seed after zero substitution. It is not visible at the ports.
- Priority each cycle is load > en > hold.
  - load: state <= seed' (seed, or 1 if seed is 0); start <= seed'; adv_cnt <= 0; period_done <= 0.
  - en with no load: state <= next.
    - If next == start: adv_cnt <= 0, period_len <= adv_cnt+1, period_done <= 1.
    - Otherwise: adv_cnt <= adv_cnt+1 (wraps modulo 2^WIDTH), period_done <= 0.
  - Neither: everything holds; period_done <= 0.
- The state never becomes zero through the function, because every entry path substitutes zero.
- period_len counts modulo 2^WIDTH. A maximal sequence length of 2^WIDTH-1 fits.

## Timing
- Reset (asynchronous assert, synchronous release) sets:
  - lfsr_out = RESET_SEED' and start = RESET_SEED'
  - adv_cnt = 0, period_done = 0, period_len = 0
- All outputs are registered. There is no combinational path from any input to any output.
- Latency:
  - load in cycle N: lfsr_out = seed' from cycle N+1.
  - en in cycle N: lfsr_out = next from cycle N+1.
  - period_done is high in cycle N+1 for the advance that returned to start in cycle N.
- load and en high together: the load wins. No step happens that cycle.
- en held continuously: one step per cycle, with no bubbles.
- Reset mid-sequence: state and counters return to their reset values immediately. Any period being measured is discarded.

## Structure
- lfsr_pkg holds:
  - tap constants TAPS_8 = 8'hB8, TAPS_16 = 16'hB400, TAPS_32 = 32'h8020_0003
  - a function lfsr_next(state, taps) that computes the next-state equation above
  - a function nz(v) that returns 1 when v == 0, otherwise v
- The period counter and start register stay in lfsr_gen. No sub-module is needed.
- An elaboration-time assertion rejects any TAPS with bit WIDTH-1 clear.

## Test plan
- Reset with WIDTH=8, TAPS=8'hB8, RESET_SEED=1, then en=1 for 4 cycles → lfsr_out goes 01, 02, 04, 08, 11.
- With the 8-bit defaults, load seed=0 → lfsr_out=01 next cycle and adv_cnt=0.
- With the 8-bit defaults, en held for 255 cycles after reset:
  - period_done pulses once, in the cycle after the 255th advance.
  - period_len=255, lfsr_out=01, adv_cnt=0.
  - No state in the sequence repeats before that point.
- load=1 and en=1 together with seed=8'h5A → lfsr_out=5A, adv_cnt=0; the next en-only cycle gives B4.
- en toggling 1,0,1,0 → state advances only in the enabled cycles and holds otherwise; period_done stays 0.
- WIDTH=16, TAPS=16'hB400, seed=16'hACE1, run 65535 steps:
  - period_len=65535.
  - Assert rst_n low mid-run → lfsr_out=0001 and adv_cnt=0 before the next clock edge.

Source files
------------

// File: rtl/lfsr_pkg.sv
// rtl/lfsr_pkg.sv - shared constants and helper functions for the LFSR generator
//
// Purpose : tap masks for the common register widths, the next-state equation
//           and zero-seed substitution, shared by the generator and its users.
// Ports   : none (package).

package lfsr_pkg;

   localparam logic [7:0]  TAPS_8  = 8'hB8;
   localparam logic [15:0] TAPS_16 = 16'hB400;
   localparam logic [31:0] TAPS_32 = 32'h8020_0003;

   localparam int MIN_WIDTH = 3;
   localparam int MAX_WIDTH = 32;

   // Left shift with the tap parity entering at bit 0. Operands are carried at
   // 32 bits so one function serves every width; callers keep the low WIDTH
   // bits, and the caller's zero-extended upper bits never reach the parity.
   function automatic logic [31:0] lfsr_next(input logic [31:0] state,
                                             input logic [31:0] taps);
      return (state << 1) | {31'd0, ^(state & taps)};
   endfunction

   // An all-zero LFSR would lock up, so zero is replaced by 1.
   function automatic logic [31:0] nz(input logic [31:0] v);
      return (v == 32'd0) ? 32'd1 : v;
   endfunction

endpackage

// File: rtl/lfsr_if.sv
// rtl/lfsr_if.sv - control and observation bundle of the LFSR generator
//
// Purpose : groups the per-cycle controls and the registered results.
// Ports   : en, load, seed          - driven by the master (user logic)
//           lfsr_out, adv_cnt,
//           period_done, period_len - driven by the slave (lfsr_gen)

interface lfsr_if #(
   parameter int WIDTH = 8
) ();

   logic             en;
   logic             load;
   logic [WIDTH-1:0] seed;
   logic [WIDTH-1:0] lfsr_out;
   logic [WIDTH-1:0] adv_cnt;
   logic             period_done;
   logic [WIDTH-1:0] period_len;

   modport master (
      output en, load, seed,
      input  lfsr_out, adv_cnt, period_done, period_len
   );

   modport slave (
      input  en, load, seed,
      output lfsr_out, adv_cnt, period_done, period_len
   );

endinterface

// File: rtl/lfsr_gen.sv
// rtl/lfsr_gen.sv - parametrised Fibonacci LFSR with seed load and period measurement
//
// Purpose : pseudo-random source. Steps on en, loads a run-time seed on load
//           (load wins over en), never enters the all-zero state, and measures
//           the number of advances taken to return to the start value.
// Ports   : clk          - clock
//           rst_n        - asynchronous active-low reset, synchronous release
//           bus.en       - advance one step this cycle
//           bus.load     - load bus.seed this cycle (priority over en)
//           bus.seed     - seed value; 0 is replaced by 1
//           bus.lfsr_out - current state (registered)
//           bus.adv_cnt  - advances since reset, load or period completion
//           bus.period_done - one-cycle pulse when the state returns to start
//           bus.period_len  - length of the last completed period (held)

module lfsr_gen
   import lfsr_pkg::*;
#(
   parameter int               WIDTH      = 8,
   parameter logic [WIDTH-1:0] TAPS       = lfsr_pkg::TAPS_8,
   parameter logic [WIDTH-1:0] RESET_SEED = 1
) (
   input  logic    clk,
   input  logic    rst_n,
   lfsr_if.slave   bus
);

   // Reset seed after zero substitution; also the reset value of start.
   localparam logic [WIDTH-1:0] RESET_VAL = WIDTH'(nz(32'(RESET_SEED)));
   localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);

   // Without the top tap the register is not a true WIDTH-bit LFSR.
   if (TAPS[WIDTH-1] != 1'b1) begin : g_bad_taps
      $error("lfsr_gen: TAPS bit WIDTH-1 must be set");
   end

   if (WIDTH < MIN_WIDTH || WIDTH > MAX_WIDTH) begin : g_bad_width
      $error("lfsr_gen: WIDTH must be within 3..32");
   end

   logic [WIDTH-1:0] state_q,  state_d;
   logic [WIDTH-1:0] start_q,  start_d;
   logic [WIDTH-1:0] adv_q,    adv_d;
   logic [WIDTH-1:0] len_q,    len_d;
   logic             done_q,   done_d;

   logic [WIDTH-1:0] step_val;
   logic [WIDTH-1:0] seed_val;

   assign step_val = WIDTH'(lfsr_next(32'(state_q), 32'(TAPS)));
   assign seed_val = WIDTH'(nz(32'(bus.seed)));

   always_comb begin
      state_d = state_q;
      start_d = start_q;
      adv_d   = adv_q;
      len_d   = len_q;
      done_d  = 1'b0;

      if (bus.load) begin
         state_d = seed_val;
         start_d = seed_val;
         adv_d   = '0;
      end else if (bus.en) begin
         state_d = step_val;
         // Comparing the value about to be entered against start lets the
         // pulse appear in the very next cycle, alongside the returned state.
         if (step_val == start_q) begin
            adv_d  = '0;
            len_d  = adv_q + ONE;
            done_d = 1'b1;
         end else begin
            adv_d  = adv_q + ONE;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= RESET_VAL;
         start_q <= RESET_VAL;
         adv_q   <= '0;
         len_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         start_q <= start_d;
         adv_q   <= adv_d;
         len_q   <= len_d;
         done_q  <= done_d;
      end
   end

   assign bus.lfsr_out    = state_q;
   assign bus.adv_cnt     = adv_q;
   assign bus.period_done = done_q;
   assign bus.period_len  = len_q;

endmodule
